// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between instruction fetch and data access.
// Data wins by default; a saturating starvation counter forces a fetch grant after STARVE_MAX losses.
module mem_port_arbiter #(
    parameter int unsigned N          = 64,
    parameter int unsigned STARVE_MAX = 3
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         if_req,
    input  logic [N-1:0] if_addr,
    output logic [31:0]  if_rdata,
    output logic         if_valid,
    output logic         if_stall,
    input  logic         dm_read,
    input  logic         dm_write,
    input  logic [N-1:0] dm_addr,
    input  logic [N-1:0] dm_wdata,
    output logic [N-1:0] dm_rdata,
    output logic         dm_done,
    output logic         dm_stall,
    output logic         mem_req,
    output logic         mem_we,
    output logic [N-1:0] mem_addr,
    output logic [N-1:0] mem_wdata,
    input  logic         mem_ready,
    input  logic [N-1:0] mem_rdata,
    input  logic         mem_rvalid
);

    localparam int unsigned CntW = $clog2(STARVE_MAX + 1);

    localparam logic [2:0] StIdle = 3'd0;
    localparam logic [2:0] StDWr  = 3'd1;
    localparam logic [2:0] StDRd  = 3'd2;
    localparam logic [2:0] StIRd  = 3'd3;
    localparam logic [2:0] StResp = 3'd4;

    logic [2:0]      stateQ, stateD;
    logic [CntW-1:0] starveQ, starveD;
    logic            ifValidQ, dmDoneQ;
    logic [31:0]     ifRdataQ;
    logic [N-1:0]    dmRdataQ;

    logic dataPend, isWrite, dataWins, grantData, grantFetch;

    always_comb begin
        dataPend   = dm_read | dm_write;
        isWrite    = dm_write & ~dm_read;
        dataWins   = dataPend & ((starveQ < CntW'(STARVE_MAX)) | ~if_req);
        grantData  = (stateQ == StIdle) & mem_ready & dataWins;
        grantFetch = (stateQ == StIdle) & mem_ready & ~dataWins & if_req;
    end

    always_comb begin
        mem_req   = grantData | grantFetch;
        mem_we    = grantData & isWrite;
        mem_addr  = grantData ? dm_addr : (grantFetch ? if_addr : '0);
        mem_wdata = (grantData & isWrite) ? dm_wdata : '0;
    end

    always_comb begin
        stateD  = stateQ;
        starveD = starveQ;
        case (stateQ)
            StIdle: begin
                if (grantData) begin
                    stateD = isWrite ? StDWr : StDRd;
                    // Only a contested loss counts against fetch.
                    if (if_req && (starveQ != CntW'(STARVE_MAX))) begin
                        starveD = starveQ + CntW'(1);
                    end
                end else if (grantFetch) begin
                    stateD  = StIRd;
                    starveD = '0;
                end
            end
            StDWr:  stateD = StIdle;
            StDRd:  if (mem_rvalid) stateD = StResp;
            StIRd:  if (mem_rvalid) stateD = StResp;
            StResp: stateD = StIdle;
            default: stateD = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stateQ   <= StIdle;
            starveQ  <= '0;
            ifValidQ <= 1'b0;
            dmDoneQ  <= 1'b0;
            ifRdataQ <= '0;
            dmRdataQ <= '0;
        end else begin
            stateQ   <= stateD;
            starveQ  <= starveD;
            ifValidQ <= (stateQ == StIRd) & mem_rvalid;
            dmDoneQ  <= ((stateQ == StDRd) & mem_rvalid) | (grantData & isWrite);
            if ((stateQ == StIRd) && mem_rvalid) begin
                ifRdataQ <= mem_rdata[31:0];
            end
            if ((stateQ == StDRd) && mem_rvalid) begin
                dmRdataQ <= mem_rdata;
            end
        end
    end

    assign if_valid = ifValidQ;
    assign if_rdata = ifRdataQ;
    assign dm_done  = dmDoneQ;
    assign dm_rdata = dmRdataQ;
    assign if_stall = if_req & ~ifValidQ;
    assign dm_stall = dataPend & ~dmDoneQ;

endmodule
